// File: rtl/fp_add_pipe.sv
// Three-stage floating-point adder/subtractor with valid/ready stream.
// Stages: unpack/align, add/subtract, normalize/round/pack.
module fp_add_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     a,
  input  logic [EXP_W+MAN_W:0]     b,
  input  logic                     sub,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     s,
  output logic [3:0]               flags
);

  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int MW4   = MAN_W + 4;
  localparam int EW2   = EXP_W + 2;
  localparam int SHMAX = MAN_W + 3;
  localparam int MAXE  = (2 ** EXP_W) - 1;

  typedef struct packed {
    logic             sx;
    logic             sy;
    logic [EXP_W-1:0] ex;
    logic [MW4-1:0]   mx;
    logic [MW4-1:0]   my;
    logic             nan;
    logic             inv;
    logic             inf;
    logic             isg;
  } s1_t;

  typedef struct packed {
    logic             sg;
    logic [EXP_W-1:0] ex;
    logic [MW4:0]     sum;
    logic             nan;
    logic             inv;
    logic             inf;
    logic             isg;
  } s2_t;

  logic stall;
  logic v1, v2;
  s1_t  n1, r1;
  s2_t  n2, r2;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  logic             sa, sb, na, nb, ia, ib, swap;
  logic [EXP_W-1:0] ea, eb, d;
  logic [MAN_W:0]   ma, mb;
  logic [MW4-1:0]   ext, sh, msk;

  always_comb begin
    sa   = a[W-1];
    sb   = b[W-1] ^ sub;
    ea   = a[W-2:MAN_W];
    eb   = b[W-2:MAN_W];
    na   = (&ea) & (|a[MAN_W-1:0]);
    nb   = (&eb) & (|b[MAN_W-1:0]);
    ia   = (&ea) & ~(|a[MAN_W-1:0]);
    ib   = (&eb) & ~(|b[MAN_W-1:0]);
    // exp == 0 flushes denormals to zero
    ma   = (ea == '0) ? '0 : {1'b1, a[MAN_W-1:0]};
    mb   = (eb == '0) ? '0 : {1'b1, b[MAN_W-1:0]};
    swap = {eb, mb} > {ea, ma};
    d    = swap ? eb - ea : ea - eb;
    ext  = {(swap ? ma : mb), 3'b000};
    sh   = ext >> d;
    msk  = ~({MW4{1'b1}} << d);
    n1     = '0;
    n1.sx  = swap ? sb : sa;
    n1.sy  = swap ? sa : sb;
    n1.ex  = swap ? eb : ea;
    n1.mx  = {(swap ? mb : ma), 3'b000};
    if (32'(d) >= SHMAX)
      n1.my = {{(MW4-1){1'b0}}, |ext};
    else
      n1.my = sh | {{(MW4-1){1'b0}}, |(ext & msk)};
    n1.nan = na | nb;
    n1.inv = ia & ib & (sa ^ sb);
    n1.inf = ia | ib;
    n1.isg = ia ? sa : sb;
  end

  logic eff;

  always_comb begin
    eff    = r1.sx ^ r1.sy;
    n2     = '0;
    n2.sum = eff ? ({1'b0, r1.mx} - {1'b0, r1.my})
                 : ({1'b0, r1.mx} + {1'b0, r1.my});
    // exact cancellation is +0 unless both inputs were -0
    n2.sg  = (n2.sum == '0) ? (r1.sx & ~eff) : r1.sx;
    n2.ex  = r1.ex;
    n2.nan = r1.nan;
    n2.inv = r1.inv;
    n2.inf = r1.inf;
    n2.isg = r1.isg;
  end

  logic [MW4:0]   v3;
  logic [MW4-1:0] n;
  logic [EW2-1:0] e, lz;
  logic           uf, up, inx;
  logic [MAN_W+1:0] mant;
  logic [MAN_W-1:0] frac;
  logic [W-1:0]   ns;
  logic [3:0]     nf;

  always_comb begin
    v3 = r2.sum;
    lz = '0;
    uf = 1'b0;
    if (v3[MW4]) begin
      n = {v3[MW4:2], v3[1] | v3[0]};
      e = {2'b00, r2.ex} + EW2'(1);
    end else begin
      for (int i = 0; i < MW4; i++)
        if (v3[i]) lz = EW2'(MW4 - 1 - i);
      n  = v3[MW4-1:0] << lz;
      uf = ({2'b00, r2.ex} <= lz);
      e  = {2'b00, r2.ex} - lz;
    end
    inx  = n[2] | n[1] | n[0];
    up   = n[2] & (n[1] | n[0] | n[3]);
    mant = {1'b0, n[MW4-1:3]} + {{(MAN_W+1){1'b0}}, up};
    if (mant[MAN_W+1]) begin
      e    = e + EW2'(1);
      frac = mant[MAN_W:1];
    end else begin
      frac = mant[MAN_W-1:0];
    end
    nf = 4'b0000;
    if (r2.nan || r2.inv) begin
      ns = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      nf = {r2.inv, 3'b000};
    end else if (r2.inf) begin
      ns = {r2.isg, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (v3 == '0) begin
      ns = {r2.sg, {(W-1){1'b0}}};
    end else if (uf) begin
      ns = {r2.sg, {(W-1){1'b0}}};
      nf = 4'b0011;
    end else if (e >= EW2'(MAXE)) begin
      ns = {r2.sg, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      nf = 4'b0101;
    end else begin
      ns = {r2.sg, e[EXP_W-1:0], frac};
      nf = {3'b000, inx};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      r1        <= '0;
      r2        <= '0;
      s         <= '0;
      flags     <= '0;
    end else if (!stall) begin
      v1        <= in_valid;
      r1        <= n1;
      v2        <= v1;
      r2        <= n2;
      out_valid <= v2;
      if (v2) begin
        s     <= ns;
        flags <= nf;
      end
    end
  end

endmodule

// File: doc/fp_add_pipe.md
Name: fp_add_pipe

Overview:
- Parametrised, pipelined IEEE-754 style floating-point adder/subtractor. Successor to the team's single-cycle 32-bit combinational adder.
- Adds generic exponent/mantissa widths, an add/sub op select, round-to-nearest-even, special-value handling, status flags and a valid/ready stream interface with backpressure.
- Sits between operand-issue logic and result writeback in the FP datapath.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, stored fraction width; word width W = 1+EXP_W+MAN_W.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  operand pair presented.
- in_ready  out  1  pipeline can accept this cycle.
- a  in  W  operand A.
- b  in  W  operand B.
- sub  in  1  0: a+b, 1: a-b (B sign inverted at input).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- s  out  W  result.
- flags  out  4  {invalid, overflow, underflow, inexact} for s.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports named clk and reset.
- Reset: out_valid=0, s=0, flags=0, all stage valid bits cleared. Reset mid-operation discards every in-flight op, and no result is emitted for them.
- Handshake:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - stall = out_valid && !out_ready. in_ready = !stall, combinational, no bubble.
  - While stalled, all stages hold, and s/flags stay stable until accepted.
  - Bubbles propagate: valid bits advance even when empty.
- Latency: exactly 3 cycles from input transfer to out_valid with no stall. Throughput 1 op/cycle.
- Stage 1, unpack/align:
  - Hidden bit = 1 if exp != 0.
  - exp == 0 is treated as zero: denormals flush to signed zero, sign preserved.
  - Classify NaN/inf/zero.
  - Swap so the larger magnitude (exp, then mantissa) is operand X.
  - Right-shift the smaller mantissa by the exponent difference into MAN_W+4 bits (guard, round, sticky). Shift >= MAN_W+3 yields sticky only.
- Stage 2, add/subtract:
  - Effective subtract when signs differ.
  - Result sign = sign of X.
  - Exact cancellation gives +0, except (-0)+(-0) = -0.
- Stage 3, normalize/round/pack:
  - Carry-out: shift right 1, exp+1.
  - Otherwise leading-zero count and left shift; if exp would reach <= 0, flush to signed zero and set underflow+inexact.
  - RNE using guard/round/sticky. Mantissa round-up overflow renormalizes (exp+1).
  - exp >= 2^EXP_W-1: result ±inf, overflow+inexact.
  - inexact = any discarded bit nonzero.
- Specials (override the arithmetic):
  - Any NaN input: canonical qNaN (sign 0, exp all ones, fraction MSB 1, rest 0).
  - inf - inf (effective): qNaN plus invalid.
  - inf ± finite: that inf, no flags.
  - Canonical NaN for default params = 0x7FC00000.
- flags are per-result, not sticky.

Test Plan:
- a=0x3F800000, b=0x40000000, sub=0 -> s=0x40400000 (3.0), flags=0, out_valid exactly 3 cycles after accept.
- a=0x3F800000, b=0x3F800000, sub=1 -> s=0x00000000, flags=0; a=b=0x80000000, sub=0 -> s=0x80000000.
- Rounding: 0x3F800000+0x33800000 (tie) -> 0x3F800000, inexact=1; 0x3F800000+0x33C00000 -> 0x3F800001, inexact=1.
- Overflow: a=b=0x7F7FFFFF, sub=0 -> 0x7F800000, overflow=1, inexact=1. inf-inf: 0x7F800000 sub 0x7F800000 -> 0x7FC00000, invalid=1.
- Backpressure: stream 6 back-to-back ops with out_ready low for cycles 4-7 -> in_ready low exactly while out_valid && !out_ready, results in order, none lost or duplicated, s stable while stalled.
- Reset with 3 ops in flight -> next cycle out_valid=0, no stale results afterwards. Rerun the 3.0 case with EXP_W=5, MAN_W=10 (half): 0x3C00+0x4000 -> 0x4200.
